// File: rtl/pool_window_2x2.sv
// Purpose: groups a raster pixel stream into non-overlapping 2x2 windows for a max-pool stage.
// Latency: one cycle from the bottom-right pixel beat to valid_out.
// Backpressure: none; every valid_in beat is consumed, and idle cycles hold all state.
//
// Ports:
//   clk, resetn         rising-edge clock, asynchronous active-low reset
//   valid_in, data_in   one pixel per valid beat, raster order
//   win_tl/tr/bl/br     registered window words, held while valid_out is low
//   valid_out           one-cycle strobe per window
//   frame_done          asserted with valid_out on the last window of a frame
module pool_window_2x2 #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 224,
  parameter int IMG_HEIGHT = 224
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] win_tl,
  output logic [DATA_WIDTH-1:0] win_tr,
  output logic [DATA_WIDTH-1:0] win_bl,
  output logic [DATA_WIDTH-1:0] win_br,
  output logic                  valid_out,
  output logic                  frame_done
);

  if ((IMG_WIDTH % 2) != 0 || IMG_WIDTH < 2) begin : g_bad_width
    $error("pool_window_2x2: IMG_WIDTH must be even and >= 2");
  end
  if ((IMG_HEIGHT % 2) != 0 || IMG_HEIGHT < 2) begin : g_bad_height
    $error("pool_window_2x2: IMG_HEIGHT must be even and >= 2");
  end

  localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] line_buf [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] hold_bl;
  logic [CW-1:0]         rd_addr_l;
  logic                  fire;
  logic                  last_win;

  // A window completes on the odd-row, odd-column beat; its left partner is
  // the even column just below, i.e. col with bit 0 cleared.
  assign fire      = valid_in && row[0] && col[0];
  assign last_win  = (row == ROW_LAST) && (col == COL_LAST);
  assign rd_addr_l = col & ~COL_ONE;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_ONE;
      end else begin
        col <= col + COL_ONE;
      end
    end
  end

  // Line buffer carries no reset: every entry is rewritten on the even row
  // before the following odd row reads it.
  always_ff @(posedge clk) begin
    if (valid_in && !row[0]) begin
      line_buf[col] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_bl <= '0;
    end else if (valid_in && row[0] && !col[0]) begin
      hold_bl <= data_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      win_tl     <= '0;
      win_tr     <= '0;
      win_bl     <= '0;
      win_br     <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= fire;
      frame_done <= fire && last_win;
      if (fire) begin
        win_tl <= line_buf[rd_addr_l];
        win_tr <= line_buf[col];
        win_bl <= hold_bl;
        win_br <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_pool_window_2x2.sv
module tb_pool_window_2x2;

  localparam int DW = 32;
  localparam int SW = 4;
  localparam int SH = 4;
  localparam int BW = 224;
  localparam int BH = 224;
  localparam int BN = BW * BH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          s_vld, s_vout, s_fdone;
  logic [DW-1:0] s_dat, s_tl, s_tr, s_bl, s_br;
  logic          b_vld, b_vout, b_fdone;
  logic [DW-1:0] b_dat, b_tl, b_tr, b_bl, b_br;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] last_tl, last_tr, last_bl, last_br;
  logic [DW-1:0] big_frame [BN];

  pool_window_2x2 #(.DATA_WIDTH(DW), .IMG_WIDTH(SW), .IMG_HEIGHT(SH)) u_small (
    .clk(clk), .resetn(resetn), .valid_in(s_vld), .data_in(s_dat),
    .win_tl(s_tl), .win_tr(s_tr), .win_bl(s_bl), .win_br(s_br),
    .valid_out(s_vout), .frame_done(s_fdone)
  );

  pool_window_2x2 #(.DATA_WIDTH(DW), .IMG_WIDTH(BW), .IMG_HEIGHT(BH)) u_big (
    .clk(clk), .resetn(resetn), .valid_in(b_vld), .data_in(b_dat),
    .win_tl(b_tl), .win_tr(b_tr), .win_bl(b_bl), .win_br(b_br),
    .valid_out(b_vout), .frame_done(b_fdone)
  );

  // Inputs change on the falling edge; outputs are sampled 1 time unit after
  // the rising edge that consumed the beat.
  task automatic drive_s(input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    s_vld = v;
    s_dat = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    b_vld = v;
    b_dat = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    s_vld = 1'b0; s_dat = '0;
    b_vld = 1'b0; b_dat = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_vout, s_fdone, s_tl, s_tr, s_bl, s_br} !== '0) begin
      errors++;
      $display("FAIL reset_small got v=%0b fd=%0b %0h %0h %0h %0h required all zero",
               s_vout, s_fdone, s_tl, s_tr, s_bl, s_br);
    end
    checks++;
    if ({b_vout, b_fdone, b_tl, b_tr, b_bl, b_br} !== '0) begin
      errors++;
      $display("FAIL reset_big got v=%0b fd=%0b required all zero", b_vout, b_fdone);
    end
    @(negedge clk);
    resetn = 1'b1;
    last_tl = '0; last_tr = '0; last_bl = '0; last_br = '0;
  endtask

  // Pixel value = p for a 4x4 frame, so a window completed at beat p is
  // (p-5, p-4, p-1, p).
  task automatic test_basic_frame();
    int nwin = 0;
    logic exp_v, exp_fd;
    for (int p = 0; p < 16; p++) begin
      drive_s(1'b1, DW'(p));
      exp_v  = ((p / 4) % 2 == 1) && (p % 2 == 1);
      exp_fd = (p == 15);
      if (s_vout === 1'b1) nwin++;
      checks++;
      if (s_vout !== exp_v) begin
        errors++; $display("FAIL t1_valid p=%0d got %0b required %0b", p, s_vout, exp_v);
      end
      checks++;
      if (s_fdone !== exp_fd) begin
        errors++; $display("FAIL t1_frame_done p=%0d got %0b required %0b", p, s_fdone, exp_fd);
      end
      if (exp_v) begin
        last_tl = DW'(p - 5); last_tr = DW'(p - 4); last_bl = DW'(p - 1); last_br = DW'(p);
        checks++;
        if ({s_tl, s_tr, s_bl, s_br} !== {last_tl, last_tr, last_bl, last_br}) begin
          errors++;
          $display("FAIL t1_window p=%0d got (%0d,%0d,%0d,%0d) required (%0d,%0d,%0d,%0d)",
                   p, s_tl, s_tr, s_bl, s_br, last_tl, last_tr, last_bl, last_br);
        end
      end
    end
    drive_s(1'b0, '0);
    checks++;
    if (s_vout !== 1'b0) begin
      errors++; $display("FAIL t1_valid_drop got %0b required 0", s_vout);
    end
    checks++;
    if (nwin != 4) begin
      errors++; $display("FAIL t1_window_count got %0d required 4", nwin);
    end
  endtask

  task automatic test_bubbles();
    int gaps;
    logic exp_v;
    for (int p = 0; p < 16; p++) begin
      drive_s(1'b1, DW'(p));
      exp_v = ((p / 4) % 2 == 1) && (p % 2 == 1);
      checks++;
      if (s_vout !== exp_v || s_fdone !== (p == 15)) begin
        errors++; $display("FAIL t2_valid p=%0d got v=%0b fd=%0b required v=%0b", p, s_vout, s_fdone, exp_v);
      end
      if (exp_v) begin
        last_tl = DW'(p - 5); last_tr = DW'(p - 4); last_bl = DW'(p - 1); last_br = DW'(p);
        checks++;
        if ({s_tl, s_tr, s_bl, s_br} !== {last_tl, last_tr, last_bl, last_br}) begin
          errors++;
          $display("FAIL t2_window p=%0d got (%0d,%0d,%0d,%0d) required (%0d,%0d,%0d,%0d)",
                   p, s_tl, s_tr, s_bl, s_br, last_tl, last_tr, last_bl, last_br);
        end
      end
      gaps = (p < 8) ? 1 : int'($urandom_range(0, 3));
      for (int g = 0; g < gaps; g++) begin
        drive_s(1'b0, 32'hDEAD_BEEF);
        checks++;
        if (s_vout !== 1'b0 || s_fdone !== 1'b0) begin
          errors++; $display("FAIL t2_bubble_valid p=%0d got v=%0b fd=%0b required 0", p, s_vout, s_fdone);
        end
        checks++;
        if ({s_tl, s_tr, s_bl, s_br} !== {last_tl, last_tr, last_bl, last_br}) begin
          errors++;
          $display("FAIL t2_bubble_hold p=%0d got (%0d,%0d,%0d,%0d) required (%0d,%0d,%0d,%0d)",
                   p, s_tl, s_tr, s_bl, s_br, last_tl, last_tr, last_bl, last_br);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int nwin = 0;
    int nfd = 0;
    int base;
    logic exp_v;
    for (int f = 0; f < 2; f++) begin
      base = (f == 0) ? 0 : 100;
      for (int p = 0; p < 16; p++) begin
        drive_s(1'b1, DW'(base + p));
        exp_v = ((p / 4) % 2 == 1) && (p % 2 == 1);
        if (s_vout === 1'b1) nwin++;
        if (s_fdone === 1'b1) nfd++;
        checks++;
        if (s_vout !== exp_v || s_fdone !== (p == 15)) begin
          errors++; $display("FAIL t3_valid f=%0d p=%0d got v=%0b fd=%0b required v=%0b", f, p, s_vout, s_fdone, exp_v);
        end
        if (exp_v) begin
          last_tl = DW'(base + p - 5); last_tr = DW'(base + p - 4);
          last_bl = DW'(base + p - 1); last_br = DW'(base + p);
          checks++;
          if ({s_tl, s_tr, s_bl, s_br} !== {last_tl, last_tr, last_bl, last_br}) begin
            errors++;
            $display("FAIL t3_window f=%0d p=%0d got (%0d,%0d,%0d,%0d) required (%0d,%0d,%0d,%0d)",
                     f, p, s_tl, s_tr, s_bl, s_br, last_tl, last_tr, last_bl, last_br);
          end
        end
      end
    end
    drive_s(1'b0, '0);
    checks++;
    if (nwin != 8 || nfd != 2) begin
      errors++; $display("FAIL t3_counts got windows=%0d frame_done=%0d required 8 and 2", nwin, nfd);
    end
  endtask

  task automatic test_signed();
    logic signed [DW-1:0] m;
    for (int p = 0; p < 16; p++) begin
      drive_s(1'b1, DW'(p - 8));
      if (p == 5) begin
        checks++;
        if (s_vout !== 1'b1 || {s_tl, s_tr, s_bl, s_br} !== {DW'(-8), DW'(-7), DW'(-4), DW'(-3)}) begin
          errors++;
          $display("FAIL t4_signed_window got v=%0b (%0d,%0d,%0d,%0d) required (-8,-7,-4,-3)",
                   s_vout, $signed(s_tl), $signed(s_tr), $signed(s_bl), $signed(s_br));
        end
        m = $signed(s_tl);
        if ($signed(s_tr) > m) m = $signed(s_tr);
        if ($signed(s_bl) > m) m = $signed(s_bl);
        if ($signed(s_br) > m) m = $signed(s_br);
        checks++;
        if (m !== -3) begin
          errors++; $display("FAIL t4_signed_max got %0d required -3", m);
        end
      end
      if (p == 15) begin
        checks++;
        if ({s_tl, s_tr, s_bl, s_br} !== {DW'(2), DW'(3), DW'(6), DW'(7)}) begin
          errors++; $display("FAIL t4_last_window got (%0d,%0d,%0d,%0d) required (2,3,6,7)",
                             $signed(s_tl), $signed(s_tr), $signed(s_bl), $signed(s_br));
        end
      end
    end
    drive_s(1'b0, '0);
  endtask

  task automatic test_mid_frame_reset();
    int nwin = 0;
    logic exp_v;
    for (int p = 0; p <= 6; p++) drive_s(1'b1, DW'(200 + p));
    @(negedge clk);
    s_vld = 1'b0;
    resetn = 1'b0;
    #1;
    checks++;
    if ({s_vout, s_fdone, s_tl, s_tr, s_bl, s_br} !== '0) begin
      errors++; $display("FAIL t5_async_reset got v=%0b tl=%0d br=%0d required all zero", s_vout, s_tl, s_br);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({s_vout, s_fdone, s_tl, s_tr, s_bl, s_br} !== '0) begin
      errors++; $display("FAIL t5_reset_hold got v=%0b tl=%0d br=%0d required all zero", s_vout, s_tl, s_br);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int p = 0; p < 16; p++) begin
      drive_s(1'b1, DW'(p));
      exp_v = ((p / 4) % 2 == 1) && (p % 2 == 1);
      if (s_vout === 1'b1) nwin++;
      checks++;
      if (s_vout !== exp_v || s_fdone !== (p == 15)) begin
        errors++; $display("FAIL t5_valid p=%0d got v=%0b fd=%0b required v=%0b", p, s_vout, s_fdone, exp_v);
      end
      if (exp_v) begin
        checks++;
        if ({s_tl, s_tr, s_bl, s_br} !== {DW'(p - 5), DW'(p - 4), DW'(p - 1), DW'(p)}) begin
          errors++;
          $display("FAIL t5_window p=%0d got (%0d,%0d,%0d,%0d) required (%0d,%0d,%0d,%0d)",
                   p, s_tl, s_tr, s_bl, s_br, p - 5, p - 4, p - 1, p);
        end
      end
    end
    drive_s(1'b0, '0);
    checks++;
    if (nwin != 4) begin
      errors++; $display("FAIL t5_window_count got %0d required 4", nwin);
    end
  endtask

  // Full-size frame of random pixels; the window for beat p is taken from
  // the stored frame at p-BW-1, p-BW, p-1, p.
  task automatic test_full_frame();
    int nwin = 0;
    int nfd = 0;
    logic exp_v;
    for (int p = 0; p < BN; p++) big_frame[p] = $urandom;
    for (int p = 0; p < BN; p++) begin
      drive_b(1'b1, big_frame[p]);
      exp_v = (((p / BW) % 2) == 1) && (((p % BW) % 2) == 1);
      if (b_vout === 1'b1) nwin++;
      if (b_fdone === 1'b1) nfd++;
      checks++;
      if (b_vout !== exp_v || b_fdone !== (p == BN - 1)) begin
        errors++; $display("FAIL t6_valid p=%0d got v=%0b fd=%0b required v=%0b", p, b_vout, b_fdone, exp_v);
      end
      if (exp_v) begin
        checks++;
        if ({b_tl, b_tr, b_bl, b_br} !==
            {big_frame[p - BW - 1], big_frame[p - BW], big_frame[p - 1], big_frame[p]}) begin
          errors++;
          $display("FAIL t6_window p=%0d got (%0h,%0h,%0h,%0h) required (%0h,%0h,%0h,%0h)",
                   p, b_tl, b_tr, b_bl, b_br,
                   big_frame[p - BW - 1], big_frame[p - BW], big_frame[p - 1], big_frame[p]);
        end
      end
    end
    drive_b(1'b0, '0);
    checks++;
    if (b_vout !== 1'b0 || b_fdone !== 1'b0) begin
      errors++; $display("FAIL t6_idle got v=%0b fd=%0b required 0", b_vout, b_fdone);
    end
    checks++;
    if (nwin != (BW / 2) * (BH / 2) || nfd != 1) begin
      errors++; $display("FAIL t6_counts got windows=%0d frame_done=%0d required %0d and 1",
                         nwin, nfd, (BW / 2) * (BH / 2));
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_bubbles();
    test_back_to_back();
    test_signed();
    test_mid_frame_reset();
    test_full_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
